// File: rtl/chameleon_flash_pkg.sv
// rtl/chameleon_flash_pkg.sv - shared SPI NOR flash opcodes, geometry and writer state types
package chameleon_flash_pkg;

    localparam logic [7:0] FLASH_WREN = 8'h06;
    localparam logic [7:0] FLASH_PP   = 8'h02;
    localparam logic [7:0] FLASH_SE   = 8'h20;
    localparam logic [7:0] FLASH_RDSR = 8'h05;
    localparam logic [7:0] FLASH_READ = 8'h03;

    localparam int PAGE_BITS   = 8;
    localparam int SECTOR_BITS = 12;

    typedef enum logic [2:0] {
        W_IDLE,
        W_NEXT,
        W_WREN,
        W_GAP,
        W_CMD,
        W_DATA,
        W_POLL,
        W_DONE
    } writer_state_e;

    typedef enum logic [1:0] {
        D_FETCH,
        D_LOAD,
        D_SHIFT
    } data_phase_e;

    function automatic logic [23:0] sector_base(input logic [23:0] addr);
        return {addr[23:SECTOR_BITS], {SECTOR_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - serialises opcode plus 24-bit address over the SPI toggle handshake
module flash_cmd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [7:0]  opcode,
    input  logic [23:0] addr,
    input  logic        spi_idle,
    output logic        send,
    output logic [7:0]  send_byte,
    output logic        done
);

    logic        active_q, active_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shreg_q, shreg_d;

    always_comb begin
        active_d  = active_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        send      = 1'b0;
        done      = 1'b0;
        send_byte = shreg_q[31:24];
        if (go) begin
            active_d = 1'b1;
            idx_d    = 3'd0;
            shreg_d  = {opcode, addr};
        end else if (active_q && spi_idle) begin
            if (idx_q == 3'd4) begin
                active_d = 1'b0;
                done     = 1'b1;
            end else begin
                send    = 1'b1;
                idx_d   = idx_q + 3'd1;
                shreg_d = {shreg_q[23:0], 8'h00};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            idx_q    <= 3'd0;
            shreg_q  <= 32'd0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
        end
    end

endmodule

// File: rtl/chameleon_spi_flash_writer.sv
// rtl/chameleon_spi_flash_writer.sv - programs a source byte image into a SPI NOR flash slot
module chameleon_spi_flash_writer
    import chameleon_flash_pkg::*;
#(
    parameter int unsigned a_bits       = 14,
    parameter int unsigned slot_bits    = 20,
    parameter int unsigned poll_limit   = 2**20,
    parameter int unsigned cs_gap_ticks = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        slot,
    input  logic              start,
    input  logic              erase,
    input  logic [a_bits-1:0] start_addr,
    input  logic [23:0]       flash_offset,
    input  logic [15:0]       amount,
    output logic              busy,
    output logic              error,
    output logic              cs_n,
    output logic              spi_req,
    input  logic              spi_ack,
    output logic [7:0]        spi_d,
    input  logic [7:0]        spi_q,
    output logic              req,
    input  logic              ack,
    output logic [a_bits-1:0] a,
    input  logic [7:0]        d
);

    localparam int GW = $clog2(cs_gap_ticks) + 1;
    localparam int PW = $clog2(poll_limit) + 1;
    localparam int SW = 24 - SECTOR_BITS;

    writer_state_e     state_q, state_d, gap_next_q, gap_next_d;
    data_phase_e       dphase_q, dphase_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
    logic [23:0]       faddr_q, faddr_d;
    logic [a_bits-1:0] a_q, a_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [SW-1:0]     er_sector_q, er_sector_d;
    logic              er_valid_q, er_valid_d;
    logic              erase_en_q, erase_en_d;
    logic              op_erase_q, op_erase_d;
    logic              sent_q, sent_d;
    logic              rdsr_q, rdsr_d;
    logic              req_q, req_d;
    logic              spi_req_q, spi_req_d;
    logic [7:0]        spi_d_q, spi_d_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              cs_n_q, cs_n_d;

    logic              spi_idle;
    logic              cmd_go, cmd_send, cmd_done;
    logic [7:0]        cmd_byte;
    logic              unused_spi_q;

    assign spi_idle     = (spi_ack == spi_req_q);
    assign unused_spi_q = ^spi_q[7:1];

    flash_cmd_seq u_cmd_seq (
        .clk       (clk),
        .reset     (reset),
        .go        (cmd_go),
        .opcode    (op_erase_q ? FLASH_SE : FLASH_PP),
        .addr      (op_erase_q ? sector_base(faddr_q) : faddr_q),
        .spi_idle  (spi_idle),
        .send      (cmd_send),
        .send_byte (cmd_byte),
        .done      (cmd_done)
    );

    always_comb begin
        state_d     = state_q;
        gap_next_d  = gap_next_q;
        dphase_d    = dphase_q;
        gap_cnt_d   = GW'(cs_gap_ticks - 1);
        poll_cnt_d  = poll_cnt_q;
        faddr_d     = faddr_q;
        a_d         = a_q;
        remaining_d = remaining_q;
        er_sector_d = er_sector_q;
        er_valid_d  = er_valid_q;
        erase_en_d  = erase_en_q;
        op_erase_d  = op_erase_q;
        sent_d      = sent_q;
        rdsr_d      = rdsr_q;
        req_d       = req_q;
        spi_req_d   = spi_req_q;
        spi_d_d     = spi_d_q;
        error_d     = error_q;
        cmd_go      = 1'b0;

        case (state_q)
            W_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (amount != 16'd0) begin
                        faddr_d     = 24'({slot, {slot_bits{1'b0}}}) + flash_offset;
                        a_d         = start_addr;
                        remaining_d = amount;
                        erase_en_d  = erase;
                        er_valid_d  = 1'b0;
                        state_d     = W_NEXT;
                    end
                end
            end
            W_NEXT: begin
                sent_d = 1'b0;
                if (erase_en_q && !(er_valid_q && er_sector_q == faddr_q[23:SECTOR_BITS])) begin
                    op_erase_d  = 1'b1;
                    er_valid_d  = 1'b1;
                    er_sector_d = faddr_q[23:SECTOR_BITS];
                end else begin
                    op_erase_d = 1'b0;
                end
                state_d = W_WREN;
            end
            W_WREN: begin
                if (spi_idle) begin
                    if (!sent_q) begin
                        spi_req_d = ~spi_req_q;
                        spi_d_d   = FLASH_WREN;
                        sent_d    = 1'b1;
                    end else begin
                        sent_d     = 1'b0;
                        gap_next_d = W_CMD;
                        state_d    = W_GAP;
                    end
                end
            end
            W_GAP: begin
                sent_d     = 1'b0;
                rdsr_d     = 1'b0;
                poll_cnt_d = '0;
                dphase_d   = D_FETCH;
                if (gap_cnt_q == '0) begin
                    state_d = gap_next_q;
                    cmd_go  = (gap_next_q == W_CMD);
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            W_CMD: begin
                if (cmd_send) begin
                    spi_req_d = ~spi_req_q;
                    spi_d_d   = cmd_byte;
                end else if (cmd_done) begin
                    if (op_erase_q) begin
                        gap_next_d = W_POLL;
                        state_d    = W_GAP;
                    end else begin
                        state_d = W_DATA;
                    end
                end
            end
            W_DATA: begin
                case (dphase_q)
                    D_FETCH: begin
                        if (ack == req_q) begin
                            req_d    = ~req_q;
                            dphase_d = D_LOAD;
                        end
                    end
                    D_LOAD: begin
                        if (ack == req_q && spi_idle) begin
                            spi_d_d   = d;
                            spi_req_d = ~spi_req_q;
                            dphase_d  = D_SHIFT;
                        end
                    end
                    D_SHIFT: begin
                        if (spi_idle) begin
                            a_d         = a_q + a_bits'(1);
                            faddr_d     = faddr_q + 24'd1;
                            remaining_d = remaining_q - 16'd1;
                            dphase_d    = D_FETCH;
                            if (remaining_q == 16'd1 || faddr_q[PAGE_BITS-1:0] == '1) begin
                                gap_next_d = W_POLL;
                                state_d    = W_GAP;
                            end
                        end
                    end
                    default: dphase_d = D_FETCH;
                endcase
            end
            W_POLL: begin
                if (spi_idle) begin
                    if (!sent_q) begin
                        spi_req_d = ~spi_req_q;
                        spi_d_d   = rdsr_q ? 8'h00 : FLASH_RDSR;
                        sent_d    = 1'b1;
                    end else begin
                        sent_d = 1'b0;
                        if (!rdsr_q) begin
                            rdsr_d = 1'b1;
                        end else if (!spi_q[0]) begin
                            state_d = W_GAP;
                            if (op_erase_q) begin
                                op_erase_d = 1'b0;
                                gap_next_d = W_WREN;
                            end else begin
                                gap_next_d = (remaining_q != 16'd0) ? W_NEXT : W_DONE;
                            end
                        end else if (poll_cnt_q == PW'(poll_limit - 1)) begin
                            error_d = 1'b1;
                            state_d = W_DONE;
                        end else begin
                            poll_cnt_d = poll_cnt_q + PW'(1);
                        end
                    end
                end
            end
            W_DONE: state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase

        cs_n_d = (state_d inside {W_IDLE, W_NEXT, W_GAP, W_DONE});
        busy_d = (state_d != W_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= W_IDLE;
            gap_next_q  <= W_IDLE;
            dphase_q    <= D_FETCH;
            gap_cnt_q   <= '0;
            poll_cnt_q  <= '0;
            faddr_q     <= 24'd0;
            a_q         <= '0;
            remaining_q <= 16'd0;
            er_sector_q <= '0;
            er_valid_q  <= 1'b0;
            erase_en_q  <= 1'b0;
            op_erase_q  <= 1'b0;
            sent_q      <= 1'b0;
            rdsr_q      <= 1'b0;
            req_q       <= 1'b0;
            spi_req_q   <= 1'b0;
            spi_d_q     <= 8'd0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            gap_next_q  <= gap_next_d;
            dphase_q    <= dphase_d;
            gap_cnt_q   <= gap_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            faddr_q     <= faddr_d;
            a_q         <= a_d;
            remaining_q <= remaining_d;
            er_sector_q <= er_sector_d;
            er_valid_q  <= er_valid_d;
            erase_en_q  <= erase_en_d;
            op_erase_q  <= op_erase_d;
            sent_q      <= sent_d;
            rdsr_q      <= rdsr_d;
            req_q       <= req_d;
            spi_req_q   <= spi_req_d;
            spi_d_q     <= spi_d_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign busy    = busy_q;
    assign error   = error_q;
    assign cs_n    = cs_n_q;
    assign spi_req = spi_req_q;
    assign spi_d   = spi_d_q;
    assign req     = req_q;
    assign a       = a_q;

endmodule

// File: tb/tb_chameleon_spi_flash_writer.sv
// tb/tb_chameleon_spi_flash_writer.sv - directed bench with SPI engine, flash and source RAM models
module tb_chameleon_spi_flash_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  slot = '0;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [13:0] start_addr = '0;
    logic [23:0] flash_offset = '0;
    logic [15:0] amount = '0;
    logic        busy, error, cs_n, spi_req, req;
    logic        spi_ack = 1'b0;
    logic [7:0]  spi_d;
    logic [7:0]  spi_q = 8'h00;
    logic        ack = 1'b0;
    logic [13:0] a;
    logic [7:0]  d = 8'h00;

    int total = 0;
    int bad = 0;

    chameleon_spi_flash_writer #(.poll_limit(16)) dut (
        .clk(clk), .reset(reset), .slot(slot), .start(start), .erase(erase),
        .start_addr(start_addr), .flash_offset(flash_offset), .amount(amount),
        .busy(busy), .error(error), .cs_n(cs_n), .spi_req(spi_req), .spi_ack(spi_ack),
        .spi_d(spi_d), .spi_q(spi_q), .req(req), .ack(ack), .a(a), .d(d)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:16383];
    logic [7:0] fmem [int];
    logic [7:0] frame [$];
    logic [7:0] spi_log [$];
    logic [7:0] op_log [$];
    int erase_log [$];
    int pp_addr_log [$];
    int pp_len_log [$];
    int eng_cnt = 0;
    int wip_timer = 0;
    bit stuck = 0;
    bit wel = 0;
    int stuck_reads = 0;
    int viol = 0;
    int page_cross = 0;
    logic last_req = 1'b0;
    logic last_cs = 1'b1;
    bit rand_mode = 0;
    int src_cnt = 0;
    int src_delay = 0;

    function automatic logic [7:0] fread(input int ad);
        return fmem.exists(ad) ? fmem[ad] : 8'hFF;
    endfunction

    function automatic int img_mismatch(input int fbase, input int sbase, input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (fread(fbase + i) !== ram[(sbase + i) & 16383]) m++;
        return m;
    endfunction

    task automatic exec_frame();
        int ad;
        int n;
        int fa;
        if (frame.size() == 0) return;
        op_log.push_back(frame[0]);
        ad = {8'h00, frame[1], frame[2], frame[3]};
        case (frame[0])
            8'h06: wel = 1;
            8'h20: if (wel && frame.size() == 4) begin
                for (int i = 0; i < 4096; i++)
                    if (fmem.exists((ad & 32'hFFF000) + i)) fmem.delete((ad & 32'hFFF000) + i);
                erase_log.push_back(ad);
                wip_timer = 20;
                wel = 0;
            end
            8'h02: if (wel && frame.size() > 4) begin
                n = frame.size() - 4;
                pp_addr_log.push_back(ad);
                pp_len_log.push_back(n);
                if ((ad & 255) + n > 256) page_cross++;
                for (int i = 0; i < n; i++) begin
                    fa = (ad & 32'hFFFF00) | ((ad + i) & 255);
                    fmem[fa] = fread(fa) & frame[4 + i];
                end
                wip_timer = 10;
                wel = 0;
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            spi_ack = 1'b0;
            eng_cnt = 0;
            frame.delete();
            last_req = 1'b0;
            last_cs = 1'b1;
        end else begin
            if (spi_req != last_req && last_req != spi_ack) viol++;
            if (cs_n != last_cs && last_req != spi_ack) viol++;
            if (cs_n && !last_cs) begin
                exec_frame();
                frame.delete();
            end
            if (wip_timer > 0) wip_timer--;
            if (spi_req != spi_ack) begin
                if (eng_cnt == 2) begin
                    eng_cnt = 0;
                    if (cs_n) viol++;
                    if (frame.size() > 0 && frame[0] == 8'h05) begin
                        spi_q = {7'b0, (stuck || wip_timer != 0)};
                        if (stuck || wip_timer != 0) stuck_reads++;
                    end else begin
                        spi_q = 8'h00;
                    end
                    frame.push_back(spi_d);
                    spi_log.push_back(spi_d);
                    spi_ack = spi_req;
                end else begin
                    eng_cnt++;
                end
            end
            last_req = spi_req;
            last_cs = cs_n;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            ack = 1'b0;
            src_cnt = 0;
        end else if (req != ack) begin
            if (src_cnt >= src_delay) begin
                d = ram[a];
                ack = req;
                src_cnt = 0;
                src_delay = rand_mode ? int'($urandom_range(7, 0)) : 0;
            end else begin
                src_cnt++;
            end
        end
    end

    task automatic clear_logs();
        spi_log.delete();
        op_log.delete();
        erase_log.delete();
        pp_addr_log.delete();
        pp_len_log.delete();
        stuck_reads = 0;
        page_cross = 0;
    endtask

    task automatic pulse_start(input logic [3:0] s, input logic er, input logic [13:0] sa,
                               input logic [23:0] off, input logic [15:0] amt);
        @(negedge clk);
        slot = s; erase = er; start_addr = sa; flash_offset = off; amount = amt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout busy=%0d after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0d want=0", error); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%0d want=1", cs_n); end
        total++; if (spi_req !== 1'b0) begin bad++; $display("FAIL reset_spi_req got=%0d want=0", spi_req); end
        total++; if (spi_d !== 8'h00) begin bad++; $display("FAIL reset_spi_d got=%h want=00", spi_d); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0d want=0", req); end
        total++; if (a !== 14'd0) begin bad++; $display("FAIL reset_a got=%h want=0", a); end
    endtask

    task automatic test_program();
        int m = 0;
        clear_logs();
        pulse_start(4'd2, 1'b0, 14'd0, 24'd0, 16'd256);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prog_busy_rise got=%0d want=1", busy); end
        wait_idle("prog");
        total++; if (spi_log[0] !== 8'h06) begin bad++; $display("FAIL prog_wren got=%h want=06", spi_log[0]); end
        total++;
        if (spi_log[1] !== 8'h02 || spi_log[2] !== 8'h20 || spi_log[3] !== 8'h00 || spi_log[4] !== 8'h00) begin
            bad++;
            $display("FAIL prog_cmd got=%h %h %h %h want=02 20 00 00", spi_log[1], spi_log[2], spi_log[3], spi_log[4]);
        end
        for (int i = 0; i < 256; i++) if (spi_log[5 + i] !== ram[i]) m++;
        total++; if (m != 0) begin bad++; $display("FAIL prog_data_bytes mismatches=%0d want=0", m); end
        total++; if (spi_log[261] !== 8'h05) begin bad++; $display("FAIL prog_rdsr got=%h want=05", spi_log[261]); end
        m = img_mismatch(32'h200000, 0, 256);
        total++; if (m != 0) begin bad++; $display("FAIL prog_image mismatches=%0d want=0", m); end
        total++; if (op_log.size() != 3) begin bad++; $display("FAIL prog_frames got=%0d want=3", op_log.size()); end
        total++; if (erase_log.size() != 0) begin bad++; $display("FAIL prog_no_erase got=%0d want=0", erase_log.size()); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL prog_error got=%0d want=0", error); end
    endtask

    task automatic test_erase_span();
        logic [7:0] exp_ops [12] = '{8'h06, 8'h20, 8'h05, 8'h06, 8'h02, 8'h05,
                                     8'h06, 8'h20, 8'h05, 8'h06, 8'h02, 8'h05};
        int m = 0;
        clear_logs();
        fmem[32'h000010] = 8'h00;
        fmem[32'h001800] = 8'h00;
        fmem[32'h000FF0] = 8'h00;
        pulse_start(4'd0, 1'b1, 14'h0100, 24'h000FF0, 16'd32);
        wait_idle("span");
        for (int i = 0; i < 12; i++) if (op_log[i] !== exp_ops[i]) m++;
        total++;
        if (op_log.size() != 12 || m != 0) begin
            bad++; $display("FAIL span_op_order size=%0d mismatches=%0d want size=12 mismatches=0", op_log.size(), m);
        end
        total++;
        if (erase_log.size() != 2 || erase_log[0] != 0 || erase_log[1] != 32'h1000) begin
            bad++; $display("FAIL span_erases n=%0d e0=%h e1=%h want n=2 e0=0 e1=1000", erase_log.size(), erase_log[0], erase_log[1]);
        end
        total++;
        if (pp_addr_log.size() != 2 || pp_addr_log[0] != 32'h0FF0 || pp_len_log[0] != 16 ||
            pp_addr_log[1] != 32'h1000 || pp_len_log[1] != 16) begin
            bad++;
            $display("FAIL span_pp n=%0d a0=%h l0=%0d a1=%h l1=%0d want n=2 a0=ff0 l0=16 a1=1000 l1=16",
                     pp_addr_log.size(), pp_addr_log[0], pp_len_log[0], pp_addr_log[1], pp_len_log[1]);
        end
        m = img_mismatch(32'h0FF0, 32'h100, 32);
        total++; if (m != 0) begin bad++; $display("FAIL span_image mismatches=%0d want=0", m); end
        total++;
        if (fread(32'h10) !== 8'hFF || fread(32'h1800) !== 8'hFF) begin
            bad++; $display("FAIL span_erased got=%h %h want=ff ff", fread(32'h10), fread(32'h1800));
        end
        total++; if (page_cross != 0) begin bad++; $display("FAIL span_page_cross got=%0d want=0", page_cross); end
    endtask

    task automatic test_poll_timeout();
        clear_logs();
        stuck = 1;
        pulse_start(4'd0, 1'b0, 14'd0, 24'h050000, 16'd1);
        wait_idle("stuck");
        stuck = 0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL stuck_error got=%0d want=1", error); end
        total++; if (stuck_reads != 16) begin bad++; $display("FAIL stuck_reads got=%0d want=16", stuck_reads); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL stuck_cs_n got=%0d want=1", cs_n); end
    endtask

    task automatic test_amount_zero();
        logic sr0, r0;
        int changes = 0;
        sr0 = spi_req;
        r0 = req;
        pulse_start(4'd1, 1'b0, 14'd0, 24'd0, 16'd0);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL zero_error_clear got=%0d want=0", error); end
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || cs_n !== 1'b1 || spi_req !== sr0 || req !== r0) changes++;
            @(negedge clk);
        end
        total++; if (changes != 0) begin bad++; $display("FAIL zero_quiet activity_cycles=%0d want=0", changes); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int m;
        clear_logs();
        pulse_start(4'd3, 1'b0, 14'd0, 24'd0, 16'd256);
        @(posedge clk);
        while (!(frame.size() == 104 && frame[0] == 8'h02 && spi_req != spi_ack) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        total++; if (n >= 5000) begin bad++; $display("FAIL mid_reach_byte100 waited=%0d want<5000", n); end
        #2 reset = 1'b1;
        #1;
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL mid_cs_n got=%0d want=1", cs_n); end
        total++;
        if (busy !== 1'b0 || error !== 1'b0 || spi_req !== 1'b0 || spi_d !== 8'h00 || req !== 1'b0 || a !== 14'd0) begin
            bad++;
            $display("FAIL mid_outputs busy=%0d err=%0d spi_req=%0d spi_d=%h req=%0d a=%h want all 0",
                     busy, error, spi_req, spi_d, req, a);
        end
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        pulse_start(4'd3, 1'b0, 14'h0200, 24'h000100, 16'd4);
        wait_idle("restart");
        m = img_mismatch(32'h300100, 32'h200, 4);
        total++; if (m != 0) begin bad++; $display("FAIL mid_restart_image mismatches=%0d want=0", m); end
        total++; if (fread(32'h300000) !== 8'hFF) begin bad++; $display("FAIL mid_aborted_pp got=%h want=ff", fread(32'h300000)); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL mid_restart_error got=%0d want=0", error); end
    endtask

    task automatic test_back_to_back();
        int m;
        int act = 0;
        clear_logs();
        rand_mode = 1;
        pulse_start(4'd1, 1'b1, 14'h3000, 24'h0000F0, 16'd40);
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid got=%0d want=1", busy); end
        pulse_start(4'd1, 1'b0, 14'd0, 24'd0, 16'd5);
        wait_idle("b2b");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cs_n !== 1'b1) act++;
        end
        rand_mode = 0;
        total++; if (act != 0) begin bad++; $display("FAIL b2b_second_start activity_cycles=%0d want=0", act); end
        total++;
        if (pp_addr_log.size() != 2 || pp_addr_log[0] != 32'h1000F0 || pp_len_log[0] != 16 ||
            pp_addr_log[1] != 32'h100100 || pp_len_log[1] != 24) begin
            bad++;
            $display("FAIL b2b_pp n=%0d a0=%h l0=%0d a1=%h l1=%0d want n=2 a0=1000f0 l0=16 a1=100100 l1=24",
                     pp_addr_log.size(), pp_addr_log[0], pp_len_log[0], pp_addr_log[1], pp_len_log[1]);
        end
        total++;
        if (erase_log.size() != 1 || erase_log[0] != 32'h100000) begin
            bad++; $display("FAIL b2b_erase n=%0d e0=%h want n=1 e0=100000", erase_log.size(), erase_log[0]);
        end
        m = img_mismatch(32'h1000F0, 32'h3000, 40);
        total++; if (m != 0) begin bad++; $display("FAIL b2b_image mismatches=%0d want=0", m); end
        total++; if (fread(32'h100000) !== 8'hFF) begin bad++; $display("FAIL b2b_ignored_write got=%h want=ff", fread(32'h100000)); end
        total++; if (viol != 0) begin bad++; $display("FAIL handshake_violations got=%0d want=0", viol); end
        total++; if (page_cross != 0) begin bad++; $display("FAIL b2b_page_cross got=%0d want=0", page_cross); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 8'((i * 37) + (i >> 7) + 5);
        test_reset();
        test_program();
        test_erase_span();
        test_poll_timeout();
        test_amount_zero();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
